// File: rtl/router_output_channel.sv
// Router output channel: two virtual-channel FIFOs sharing one registered link.
// The VC matching polarity is the only one that may send in a given cycle.
module router_output_channel #(
    parameter int DEPTH = 4,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          polarity,
    input  logic          wr_en,
    input  logic          wr_vc,
    input  logic [DW-1:0] wr_data,
    output logic [1:0]    wr_ready,
    input  logic          so_ready,
    output logic          so_send,
    output logic [DW-1:0] so_data,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [DW-1:0] mem_q [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] wr_ptr_d [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [AW-1:0] rd_ptr_d [2];
    logic [AW:0]   count_q  [2];
    logic [AW:0]   count_d  [2];
    logic [1:0]    push;
    logic [1:0]    pop;
    logic          overflow_q, overflow_d;
    logic          so_send_q, so_send_d;
    logic [DW-1:0] so_data_q, so_data_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Readiness and pops use only pre-edge counts, so a full VC rejects a write even while popping.
    always_comb begin
        wr_ready = 2'b00;
        push     = 2'b00;
        pop      = 2'b00;
        for (int v = 0; v < 2; v++) begin
            wr_ready[v] = (count_q[v] < FULL_CNT);
            push[v]     = wr_en && (wr_vc == 1'(v)) && (count_q[v] < FULL_CNT);
            pop[v]      = so_ready && (polarity == 1'(v)) && (count_q[v] != '0);
            wr_ptr_d[v] = push[v] ? ptr_inc(wr_ptr_q[v]) : wr_ptr_q[v];
            rd_ptr_d[v] = pop[v]  ? ptr_inc(rd_ptr_q[v]) : rd_ptr_q[v];
            count_d[v]  = count_q[v] + (AW+1)'(push[v]) - (AW+1)'(pop[v]);
        end
    end

    always_comb begin
        overflow_d = overflow_q | (wr_en & ~wr_ready[wr_vc]);
        so_send_d  = |pop;
        so_data_d  = '0;
        if (|pop) begin
            so_data_d = mem_q[polarity][rd_ptr_q[polarity]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            overflow_q <= 1'b0;
            so_send_q  <= 1'b0;
            so_data_q  <= '0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                count_q[v]  <= count_d[v];
            end
            overflow_q <= overflow_d;
            so_send_q  <= so_send_d;
            so_data_q  <= so_data_d;
        end
    end

    // Storage is never cleared; reset only forgets it through the pointers and counts.
    always_ff @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            if (push[v]) begin
                mem_q[v][wr_ptr_q[v]] <= wr_data;
            end
        end
    end

    assign so_send  = so_send_q;
    assign so_data  = so_data_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_router_output_channel.sv
// Directed bench for router_output_channel with per-VC expected-packet queues
// consumed by an independent link monitor.
module tb_router_output_channel;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic          wr_en;
    logic          wr_vc;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_ready;
    logic          so_ready;
    logic          so_send;
    logic [DW-1:0] so_data;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    logic          mon_pol;
    logic          mon_rst;
    logic [DW-1:0] mon_exp;

    router_output_channel #(.DEPTH(4), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .wr_en    (wr_en),
        .wr_vc    (wr_vc),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .so_ready (so_ready),
        .so_send  (so_send),
        .so_data  (so_data),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put(input logic vc, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_vc   = vc;
        wr_data = data;
    endtask

    // Link monitor: every send must match the oldest expected packet of the VC selected at that edge.
    initial begin
        forever begin
            @(posedge clk);
            mon_pol = polarity;
            mon_rst = reset;
            #1;
            if (!mon_rst && so_send) begin
                if ((mon_pol ? q1.size() : q0.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send: vc%0d data 0x%0h with nothing expected at %0t",
                             mon_pol, so_data, $time);
                end else begin
                    mon_exp = mon_pol ? q1.pop_front() : q0.pop_front();
                    check(mon_pol ? "send_data_vc1" : "send_data_vc0", so_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; polarity = 1'b0; wr_en = 1'b0; wr_vc = 1'b0;
        wr_data = '0; so_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("reset_so_send", 64'(so_send), 64'd0);
        check("reset_so_data", so_data, 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_wr_ready", 64'(wr_ready), 64'd3);

        // Basic send: written at edge 1, on the link after edge 2, gone after edge 3.
        polarity = 1'b0; so_ready = 1'b1;
        put(1'b0, 64'hA5); q0.push_back(64'hA5);
        tick(); wr_en = 1'b0;
        check("no_bypass_so_send", 64'(so_send), 64'd0);
        tick();
        check("basic_so_send", 64'(so_send), 64'd1);
        check("basic_so_data", so_data, 64'hA5);
        tick();
        check("basic_so_send_drop", 64'(so_send), 64'd0);
        check("basic_so_data_zero", so_data, 64'd0);

        // Polarity hold: VC1 packet waits while polarity selects VC0.
        put(1'b1, 64'h11); q1.push_back(64'h11);
        tick(); wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pol_hold_so_send", 64'(so_send), 64'd0);
        end
        polarity = 1'b1;
        tick();
        check("pol_match_so_send", 64'(so_send), 64'd1);
        check("pol_match_so_data", so_data, 64'h11);
        polarity = 1'b0;
        tick();

        // Full and overflow on VC0 with the link stalled.
        so_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b0, 64'h100 + 64'(i)); q0.push_back(64'h100 + 64'(i));
            tick();
        end
        wr_en = 1'b0;
        check("full_wr_ready", 64'(wr_ready), 64'd2);
        check("full_no_overflow", 64'(overflow), 64'd0);
        put(1'b0, 64'h104);
        tick(); wr_en = 1'b0;
        check("overflow_set", 64'(overflow), 64'd1);
        check("overflow_wr_ready", 64'(wr_ready), 64'd2);
        so_ready = 1'b1;
        repeat (5) tick();
        check("drained_wr_ready", 64'(wr_ready), 64'd3);
        check("overflow_sticky", 64'(overflow), 64'd1);

        // Full VC with a simultaneous pop still rejects the write.
        so_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b0, 64'h201 + 64'(i)); q0.push_back(64'h201 + 64'(i));
            tick();
        end
        so_ready = 1'b1;
        put(1'b0, 64'h2FF);
        tick(); wr_en = 1'b0;
        check("full_pop_wr_ready", 64'(wr_ready), 64'd3);
        repeat (5) tick();
        check("full_pop_drained", 64'(wr_ready), 64'd3);

        // Streaming through VC1 with write and pop every cycle, wrapping pointers.
        polarity = 1'b1; so_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            check("stream_wr_ready", 64'(wr_ready), 64'd3);
            put(1'b1, 64'(k)); q1.push_back(64'(k));
            tick();
            check("stream_so_send", 64'(so_send), (k >= 2) ? 64'd1 : 64'd0);
        end
        wr_en = 1'b0;
        tick();
        check("stream_last_send", 64'(so_send), 64'd1);
        check("stream_last_data", so_data, 64'd10);
        tick();
        check("stream_idle", 64'(so_send), 64'd0);

        // All-zero packet is still a packet.
        polarity = 1'b0;
        put(1'b0, 64'h0); q0.push_back(64'h0);
        tick(); wr_en = 1'b0;
        tick();
        check("zero_so_send", 64'(so_send), 64'd1);
        check("zero_so_data", so_data, 64'd0);
        tick();

        // Reset mid-operation discards buffered packets and clears overflow.
        so_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(1'b0, 64'h301 + 64'(i));
            tick();
        end
        wr_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_so_send", 64'(so_send), 64'd0);
        check("midrst_wr_ready", 64'(wr_ready), 64'd3);
        check("midrst_overflow", 64'(overflow), 64'd0);
        so_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            polarity = 1'(i);
            tick();
            check("midrst_no_stale", 64'(so_send), 64'd0);
        end

        tick();
        check("vc0_queue_empty", 64'(q0.size()), 64'd0);
        check("vc1_queue_empty", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
